// File: rtl/rsa_pkg.sv
// Shared width, FSM state encoding and modular-multiplier latency for the RSA decrypt path.
`default_nettype none

package rsa_pkg;

  localparam int RSA_W      = 16;
  localparam int RSA_MM_LAT = RSA_W + 1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    SQR   = 3'd2,
    MUL   = 3'd3,
    DONE  = 3'd4
  } rsa_state_t;

endpackage

`default_nettype wire

// File: rtl/rsa_modmul.sv
// Bit-serial interleaved shift-add-reduce modular multiplier: p = a*b mod n, W+1 cycles start->done.
`default_nettype none

module rsa_modmul
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] n,
  output logic [W-1:0] p,
  output logic         done
);

  localparam int KW = (W > 1) ? $clog2(W) : 1;

  logic [W+1:0]  r_p;
  logic [W+1:0]  r_a;
  logic [W+1:0]  r_n;
  logic [W-1:0]  r_b;
  logic [KW-1:0] r_k;
  logic          r_run;
  logic          r_done;

  logic [W+1:0]  w_sum;
  logic [W+1:0]  w_red1;
  logic [W+1:0]  w_red2;

  // 2P + a < 3N, so two conditional subtracts always land below N.
  always_comb begin
    w_sum  = (r_p << 1) + (r_b[r_k] ? r_a : '0);
    w_red1 = (w_sum  >= r_n) ? (w_sum  - r_n) : w_sum;
    w_red2 = (w_red1 >= r_n) ? (w_red1 - r_n) : w_red1;
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_p    <= '0;
      r_a    <= '0;
      r_n    <= '0;
      r_b    <= '0;
      r_k    <= '0;
      r_run  <= 1'b0;
      r_done <= 1'b0;
    end else if (start) begin
      r_p    <= '0;
      r_a    <= {2'b00, a};
      r_n    <= {2'b00, n};
      r_b    <= b;
      r_k    <= KW'(W - 1);
      r_run  <= 1'b1;
      r_done <= 1'b0;
    end else if (r_run) begin
      r_p <= w_red2;
      if (r_k == '0) begin
        r_run  <= 1'b0;
        r_done <= 1'b1;
      end else begin
        r_k <= r_k - 1'b1;
      end
    end else begin
      r_done <= 1'b0;
    end
  end

  assign p    = r_p[W-1:0];
  assign done = r_done;

endmodule

`default_nettype wire

// File: rtl/rsa_modexp_decrypt.sv
// RSA decrypt M = C^D mod N, left-to-right square-and-multiply over a shared rsa_modmul.
// Define RSA_CONST_TIME_EN to always run the multiply step (latency independent of D).
`default_nettype none

module rsa_modexp_decrypt
  import rsa_pkg::*;
#(
  parameter int W = RSA_W
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Load,
  input  logic [W-1:0] C,
  input  logic [W-1:0] D,
  input  logic [W-1:0] N,
  output logic [W-1:0] M,
  output logic         Done,
  output logic         Busy,
  output logic         Err
);

  localparam int IW = (W > 1) ? $clog2(W) : 1;
`ifdef RSA_CONST_TIME_EN
  localparam bit CONST_TIME = 1'b1;
`else
  localparam bit CONST_TIME = 1'b0;
`endif

  rsa_state_t    r_state, w_next;
  logic [W-1:0]  r_c, r_d, r_n, r_acc, r_m;
  logic [IW-1:0] r_i;
  logic          r_err_p, r_err, r_done, r_busy;

  logic          w_start, w_acc_we, w_i_dec, w_bit, w_chk_bad, w_mm_done;
  logic [W-1:0]  w_a, w_b, w_acc_nx, w_mm_p;

  rsa_modmul #(.W(W)) u_modmul (
    .Clk   (Clk),
    .Reset (Reset),
    .start (w_start),
    .a     (w_a),
    .b     (w_b),
    .n     (r_n),
    .p     (w_mm_p),
    .done  (w_mm_done)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // The next product is launched in the same cycle the previous one completes,
  // forwarding the fresh product as the new operand, so each step costs W+1 cycles.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_a       = r_acc;
    w_b       = r_acc;
    w_acc_nx  = r_acc;
    w_acc_we  = 1'b0;
    w_i_dec   = 1'b0;
    w_bit     = r_d[r_i];
    w_chk_bad = (r_n < W'(2)) || (r_c >= r_n);
    case (r_state)
      IDLE: if (Load) w_next = CHECK;
      CHECK: begin
        if (w_chk_bad) begin
          w_next = DONE;
        end else begin
          w_next  = SQR;
          w_start = 1'b1;
          w_a     = W'(1);
          w_b     = W'(1);
        end
      end
      SQR: begin
        if (w_mm_done) begin
          w_acc_we = 1'b1;
          w_acc_nx = w_mm_p;
          if (CONST_TIME || w_bit) begin
            w_next  = MUL;
            w_start = 1'b1;
            w_a     = w_mm_p;
            w_b     = r_c;
          end else if (r_i == '0) begin
            w_next = DONE;
          end else begin
            w_i_dec = 1'b1;
            w_start = 1'b1;
            w_a     = w_mm_p;
            w_b     = w_mm_p;
          end
        end
      end
      MUL: begin
        if (w_mm_done) begin
          w_acc_we = 1'b1;
          w_acc_nx = w_bit ? w_mm_p : r_acc;
          if (r_i == '0) begin
            w_next = DONE;
          end else begin
            w_next  = SQR;
            w_i_dec = 1'b1;
            w_start = 1'b1;
            w_a     = w_acc_nx;
            w_b     = w_acc_nx;
          end
        end
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_c     <= '0;
      r_d     <= '0;
      r_n     <= '0;
      r_acc   <= '0;
      r_i     <= '0;
      r_err_p <= 1'b0;
      r_m     <= '0;
      r_err   <= 1'b0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_done <= (r_state == DONE);
      if (r_state == IDLE && Load) begin
        r_c    <= C;
        r_d    <= D;
        r_n    <= N;
        r_busy <= 1'b1;
      end
      if (r_state == CHECK) begin
        r_acc   <= w_chk_bad ? '0 : W'(1);
        r_err_p <= w_chk_bad;
        r_i     <= IW'(W - 1);
      end
      if (w_acc_we) r_acc <= w_acc_nx;
      if (w_i_dec)  r_i   <= r_i - 1'b1;
      // Outputs are published together with the Done pulse.
      if (r_state == DONE) begin
        r_m    <= r_acc;
        r_err  <= r_err_p;
        r_busy <= 1'b0;
      end
    end
  end

  assign M    = r_m;
  assign Done = r_done;
  assign Busy = r_busy;
  assign Err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_rsa_modexp_decrypt.sv
// Directed self-checking bench for rsa_modexp_decrypt with a right-to-left reference model.
`default_nettype none

module tb_rsa_modexp_decrypt;
  import rsa_pkg::*;

  localparam int W     = RSA_W;
  localparam int LIMIT = 3000;

  logic         Clk = 1'b0;
  logic         Reset, Load;
  logic [W-1:0] C, D, N, M;
  logic         Done, Busy, Err;

  int vectors = 0;
  int miscompares = 0;

  always #5 Clk = ~Clk;

  rsa_modexp_decrypt #(.W(W)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .Load  (Load),
    .C     (C),
    .D     (D),
    .N     (N),
    .M     (M),
    .Done  (Done),
    .Busy  (Busy),
    .Err   (Err)
  );

  function automatic logic [W-1:0] ref_modexp(input logic [W-1:0] c, input logic [W-1:0] d,
                                               input logic [W-1:0] n);
    longint r = 1;
    longint b = longint'(c) % longint'(n);
    for (int k = 0; k < W; k++) begin
      if (d[k]) r = (r * b) % longint'(n);
      b = (b * b) % longint'(n);
    end
    return W'(r % longint'(n));
  endfunction

  function automatic int exp_lat(input logic [W-1:0] d);
`ifdef RSA_CONST_TIME_EN
    return 2 + 2 * W * RSA_MM_LAT;
`else
    return 2 + RSA_MM_LAT * (W + $countones(d));
`endif
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (lat < LIMIT) begin
      @(posedge Clk);
      lat++;
      #1;
      if (Done) break;
    end
    chk("done_seen", {63'd0, Done}, 64'd1);
  endtask

  task automatic run_op(input logic [W-1:0] c, input logic [W-1:0] d, input logic [W-1:0] n,
                        output int lat);
    @(posedge Clk);
    #1;
    C = c; D = d; N = n; Load = 1'b1;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    wait_done(lat);
  endtask

  initial begin
    int lat;
    logic [W-1:0] rc, rd, rn;

    Reset = 1'b1; Load = 1'b0; C = '0; D = '0; N = '0;
    repeat (3) @(posedge Clk);
    #1;
    chk("reset_M", 64'(M), 64'd0);
    chk("reset_Done", 64'(Done), 64'd0);
    chk("reset_Busy", 64'(Busy), 64'd0);
    chk("reset_Err", 64'(Err), 64'd0);
    Reset = 1'b0;

    // Textbook RSA pair
    run_op(16'd2790, 16'd2753, 16'd3233, lat);
    chk("rsa3233_lat", 64'(lat), 64'(exp_lat(16'd2753)));
    chk("rsa3233_M", 64'(M), 64'd65);
    chk("rsa3233_Err", 64'(Err), 64'd0);
    @(posedge Clk);
    #1;
    chk("done_pulse_len", 64'(Done), 64'd0);
    chk("busy_after_done", 64'(Busy), 64'd0);
    chk("M_hold", 64'(M), 64'd65);

    run_op(16'd9, 16'd3, 16'd1000, lat);
    chk("cube_M", 64'(M), 64'd729);
    chk("cube_lat", 64'(lat), 64'(exp_lat(16'd3)));
    run_op(16'd9, 16'd0, 16'd1000, lat);
    chk("d0_M", 64'(M), 64'd1);
    chk("d0_lat", 64'(lat), 64'(exp_lat(16'd0)));

    run_op(16'd0, 16'd5, 16'd1, lat);
    chk("n1_lat", 64'(lat), 64'd2);
    chk("n1_M", 64'(M), 64'd0);
    chk("n1_Err", 64'(Err), 64'd1);
    run_op(16'd150, 16'd7, 16'd100, lat);
    chk("c_ge_n_lat", 64'(lat), 64'd2);
    chk("c_ge_n_M", 64'(M), 64'd0);
    chk("c_ge_n_Err", 64'(Err), 64'd1);

    run_op(16'd0, 16'd9, 16'd77, lat);
    chk("c0_M", 64'(M), 64'd0);
    chk("c0_Err", 64'(Err), 64'd0);

    run_op(16'd65534, 16'd65535, 16'd65535, lat);
    chk("nmax_M", 64'(M), 64'd65534);
    chk("nmax_model", 64'(M), 64'(ref_modexp(16'd65534, 16'd65535, 16'd65535)));
    chk("nmax_lat", 64'(lat), 64'(exp_lat(16'd65535)));

    for (int v = 0; v < 5; v++) begin
      rn = W'($urandom_range(65535, 2));
      rc = W'($urandom_range(int'(rn) - 1, 0));
      rd = W'($urandom_range(65535, 0));
      run_op(rc, rd, rn, lat);
      chk("rand_M", 64'(M), 64'(ref_modexp(rc, rd, rn)));
      chk("rand_lat", 64'(lat), 64'(exp_lat(rd)));
    end

    // Load while busy must be ignored
    @(posedge Clk);
    #1;
    C = 16'd2790; D = 16'd2753; N = 16'd3233; Load = 1'b1;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    repeat (5) @(posedge Clk);
    #1;
    chk("busy_mid_op", 64'(Busy), 64'd1);
    C = 16'd5; D = 16'd3; Load = 1'b1;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    wait_done(lat);
    chk("ignored_load_M", 64'(M), 64'd65);
    repeat (3) @(posedge Clk);
    #1;
    chk("ignored_load_idle", 64'(Busy), 64'd0);

    // Asynchronous reset in the middle of a squaring step
    @(posedge Clk);
    #1;
    C = 16'd65534; D = 16'd65535; N = 16'd65535; Load = 1'b1;
    @(posedge Clk);
    #1;
    Load = 1'b0;
    repeat (10) @(posedge Clk);
    #3;
    Reset = 1'b1;
    #1;
    chk("areset_M", 64'(M), 64'd0);
    chk("areset_Done", 64'(Done), 64'd0);
    chk("areset_Busy", 64'(Busy), 64'd0);
    chk("areset_Err", 64'(Err), 64'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;
    run_op(16'd2790, 16'd2753, 16'd3233, lat);
    chk("post_reset_M", 64'(M), 64'd65);
    chk("post_reset_lat", 64'(lat), 64'(exp_lat(16'd2753)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
